// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback definitions: default widths, the PC register index,
// the arbitration priority states and the writeback bundle layout.
package wb_port_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 4;

  // Writes to this register index redirect the fetch PC.
  localparam logic [3:0] PC_REG_IDX = 4'hF;

  typedef enum logic [0:0] {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } arb_state_e;

  // One writeback: same layout as the WB stage register.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] pc;
    logic [DEF_DATA_W-1:0] value;
    logic [DEF_REG_AW-1:0] destination;
  } wb_bundle_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of both writeback request ports plus the arbitrated write port.
// master = the two requesters / register file side, slave = the arbiter.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
);

  logic              i_A_Valid;
  logic [DATA_W-1:0] i_A_Pc;
  logic [DATA_W-1:0] i_A_Write_Back_Value;
  logic [REG_AW-1:0] i_A_Destination;
  logic              o_A_Ready;

  logic              i_B_Valid;
  logic [DATA_W-1:0] i_B_Pc;
  logic [DATA_W-1:0] i_B_Write_Back_Value;
  logic [REG_AW-1:0] i_B_Destination;
  logic              o_B_Ready;

  logic [DATA_W-1:0] o_Pc;
  logic              o_Sig_Write_Back_Enable;
  logic [DATA_W-1:0] o_Write_Back_Value;
  logic [REG_AW-1:0] o_Destination;
  logic              o_Pc_Redirect;

  modport master (
    output i_A_Valid, i_A_Pc, i_A_Write_Back_Value, i_A_Destination,
    output i_B_Valid, i_B_Pc, i_B_Write_Back_Value, i_B_Destination,
    input  o_A_Ready, o_B_Ready,
    input  o_Pc, o_Sig_Write_Back_Enable, o_Write_Back_Value, o_Destination, o_Pc_Redirect
  );

  modport slave (
    input  i_A_Valid, i_A_Pc, i_A_Write_Back_Value, i_A_Destination,
    input  i_B_Valid, i_B_Pc, i_B_Write_Back_Value, i_B_Destination,
    output o_A_Ready, o_B_Ready,
    output o_Pc, o_Sig_Write_Back_Enable, o_Write_Back_Value, o_Destination, o_Pc_Redirect
  );

endinterface

// File: rtl/wb_grant_logic.sv
// Combinational grant selection between the pipeline writeback (A) and the
// long-latency writeback (B). At most one grant per cycle.
module wb_grant_logic
  import wb_port_arbiter_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              i_a_valid,
  input  logic [REG_AW-1:0] i_a_dest,
  input  logic              i_b_valid,
  input  logic [REG_AW-1:0] i_b_dest,
  input  arb_state_e        i_state,
  output logic              o_grant_a,
  output logic              o_grant_b
);

  logic w_same_dest;

  // B wins when alone, when it is the older write to the same register,
  // or when it has been starved long enough to hold priority.
  always_comb begin
    w_same_dest = (i_a_dest == i_b_dest);
    o_grant_b   = i_b_valid & (~i_a_valid | w_same_dest | (i_state == PRIO_B));
    o_grant_a   = i_a_valid & ~o_grant_b;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order pipeline
// writeback (A) and the long-latency writeback (B). One registered write
// per cycle; B is guaranteed service after STARVE_MAX refusals.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_AW     = DEF_REG_AW,
  parameter int STARVE_MAX = 3
) (
  input logic            clk,
  input logic            reset,
  wb_port_arbiter_if.slave bus
);

  localparam logic [0:0] S_PRIO_A = PRIO_A;
  localparam logic [0:0] S_PRIO_B = PRIO_B;
  localparam logic [3:0] CNT_MAX  = 4'(STARVE_MAX);

  logic              w_grant_a;
  logic              w_grant_b;
  logic [DATA_W-1:0] w_sel_pc;
  logic [DATA_W-1:0] w_sel_val;
  logic [REG_AW-1:0] w_sel_dst;
  logic [3:0]        w_starve_nxt;
  logic [0:0]        w_state_nxt;

  logic [3:0]        r_starve_cnt;
  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_pc_p1;
  logic [DATA_W-1:0] r_val_p1;
  logic [REG_AW-1:0] r_dst_p1;
  logic              r_vld_p1;
  logic              r_redir_p1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= CNT_MAX) return CNT_MAX;
    return v + 4'd1;
  endfunction

  wb_grant_logic #(.REG_AW(REG_AW)) u_grant (
    .i_a_valid (bus.i_A_Valid),
    .i_a_dest  (bus.i_A_Destination),
    .i_b_valid (bus.i_B_Valid),
    .i_b_dest  (bus.i_B_Destination),
    .i_state   (arb_state_e'(r_state)),
    .o_grant_a (w_grant_a),
    .o_grant_b (w_grant_b)
  );

  // Readies are suppressed while reset is held so no request is consumed.
  assign bus.o_A_Ready = w_grant_a & reset;
  assign bus.o_B_Ready = w_grant_b & reset;

  // Winner payload mux and next starvation count / priority state.
  always_comb begin
    w_sel_pc  = w_grant_b ? bus.i_B_Pc               : bus.i_A_Pc;
    w_sel_val = w_grant_b ? bus.i_B_Write_Back_Value : bus.i_A_Write_Back_Value;
    w_sel_dst = w_grant_b ? bus.i_B_Destination      : bus.i_A_Destination;

    w_starve_nxt = r_starve_cnt;
    if (w_grant_b)          w_starve_nxt = 4'd0;
    else if (bus.i_B_Valid) w_starve_nxt = sat_inc(r_starve_cnt);

    w_state_nxt = r_state;
    case (r_state)
      S_PRIO_A: if (w_starve_nxt == CNT_MAX) w_state_nxt = S_PRIO_B;
      S_PRIO_B: if (w_grant_b)               w_state_nxt = S_PRIO_A;
      default:                               w_state_nxt = S_PRIO_A;
    endcase
  end

  // Stage p1: registered write port plus arbitration state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_starve_cnt <= 4'd0;
      r_state      <= S_PRIO_A;
      r_vld_p1     <= 1'b0;
      r_redir_p1   <= 1'b0;
      r_pc_p1      <= '0;
      r_val_p1     <= '0;
      r_dst_p1     <= '0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_state      <= w_state_nxt;
      r_vld_p1     <= w_grant_a | w_grant_b;
      r_redir_p1   <= (w_grant_a | w_grant_b) & (w_sel_dst == REG_AW'(PC_REG_IDX));
      if (w_grant_a | w_grant_b) begin
        r_pc_p1  <= w_sel_pc;
        r_val_p1 <= w_sel_val;
        r_dst_p1 <= w_sel_dst;
      end
    end
  end

  assign bus.o_Pc                    = r_pc_p1;
  assign bus.o_Sig_Write_Back_Enable = r_vld_p1;
  assign bus.o_Write_Back_Value      = r_val_p1;
  assign bus.o_Destination           = r_dst_p1;
  assign bus.o_Pc_Redirect           = r_redir_p1;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: requester queues drive A and B,
// hand-ordered expected writes go into a scoreboard that a negedge
// monitor drains whenever the write strobe is seen.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] val;
    logic [3:0]  dst;
    logic        redir;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(32), .REG_AW(4)) bus ();

  wb_port_arbiter #(.DATA_W(32), .REG_AW(4), .STARVE_MAX(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];
  wb_bundle_t qa[$];
  wb_bundle_t qb[$];
  logic [31:0] rf [16];
  logic last_a_rdy, last_b_rdy;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] val,
                          input logic [3:0] dst, input logic redir);
    exp_t e;
    e.pc = pc; e.val = val; e.dst = dst; e.redir = redir;
    exp_q.push_back(e);
  endtask

  function automatic wb_bundle_t mk(input logic [31:0] pc, input logic [31:0] val,
                                    input logic [3:0] dst);
    wb_bundle_t t;
    t.pc = pc; t.value = val; t.destination = dst;
    return t;
  endfunction

  // One clock cycle of both requesters: present queue heads, sample the
  // handshake just before the edge, retire accepted entries after it.
  task automatic step();
    logic acc_a, acc_b;
    bus.i_A_Valid = (qa.size() > 0);
    if (qa.size() > 0) begin
      bus.i_A_Pc = qa[0].pc; bus.i_A_Write_Back_Value = qa[0].value;
      bus.i_A_Destination = qa[0].destination;
    end
    bus.i_B_Valid = (qb.size() > 0);
    if (qb.size() > 0) begin
      bus.i_B_Pc = qb[0].pc; bus.i_B_Write_Back_Value = qb[0].value;
      bus.i_B_Destination = qb[0].destination;
    end
    #3;
    last_a_rdy = bus.o_A_Ready;
    last_b_rdy = bus.o_B_Ready;
    acc_a = bus.i_A_Valid && bus.o_A_Ready;
    acc_b = bus.i_B_Valid && bus.o_B_Ready;
    @(posedge clk);
    #1;
    if (acc_a) void'(qa.pop_front());
    if (acc_b) void'(qb.pop_front());
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < 40) begin
      step();
      n++;
    end
    if (qa.size() > 0 || qb.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: requests left A=%0d B=%0d required 0", name, qa.size(), qb.size());
    end
    @(negedge clk);
    #1;
  endtask

  // Scoreboard monitor: every strobed write must match the next expected one.
  always @(negedge clk) begin
    if (bus.o_Sig_Write_Back_Enable === 1'b1) begin
      rf[bus.o_Destination] = bus.o_Write_Back_Value;
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_write: got pc=%h val=%h dst=%h required no write",
                 bus.o_Pc, bus.o_Write_Back_Value, bus.o_Destination);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_write {pc,val,dst,redir}",
              {59'd0, bus.o_Pc, bus.o_Write_Back_Value, bus.o_Destination, bus.o_Pc_Redirect},
              {59'd0, e.pc, e.val, e.dst, e.redir});
      end
    end
  end

  initial begin
    #20000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    bus.i_A_Valid = 0; bus.i_A_Pc = 0; bus.i_A_Write_Back_Value = 0; bus.i_A_Destination = 0;
    bus.i_B_Valid = 0; bus.i_B_Pc = 0; bus.i_B_Write_Back_Value = 0; bus.i_B_Destination = 0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;

    // Reset held two cycles with A requesting.
    reset = 1'b0;
    qa.push_back(mk(32'h1000, 32'hABCD1234, 4'hA));
    push_exp(32'h1000, 32'hABCD1234, 4'hA, 1'b0);
    step();
    check("reset_a_ready_c1", last_a_rdy, 1'b0);
    step();
    check("reset_a_ready_c2", last_a_rdy, 1'b0);
    check("reset_b_ready", last_b_rdy, 1'b0);
    check("reset_wbe", bus.o_Sig_Write_Back_Enable, 1'b0);
    check("reset_pc", bus.o_Pc, 32'h0);
    check("reset_val", bus.o_Write_Back_Value, 32'h0);
    check("reset_dst", bus.o_Destination, 4'h0);
    check("reset_redir", bus.o_Pc_Redirect, 1'b0);
    reset = 1'b1;
    drain("after_reset");

    // Starvation bound: B (dst 5) refused three times, then granted.
    for (int k = 0; k < 7; k++) qa.push_back(mk(32'h100 + 4*k, 32'hA0000000 + k, 4'h3));
    qb.push_back(mk(32'h200, 32'hB0000000, 4'h5));
    qb.push_back(mk(32'h204, 32'hB0000001, 4'h5));
    push_exp(32'h100, 32'hA0000000, 4'h3, 1'b0);
    push_exp(32'h104, 32'hA0000001, 4'h3, 1'b0);
    push_exp(32'h108, 32'hA0000002, 4'h3, 1'b0);
    push_exp(32'h200, 32'hB0000000, 4'h5, 1'b0);
    push_exp(32'h10C, 32'hA0000003, 4'h3, 1'b0);
    push_exp(32'h110, 32'hA0000004, 4'h3, 1'b0);
    push_exp(32'h114, 32'hA0000005, 4'h3, 1'b0);
    push_exp(32'h204, 32'hB0000001, 4'h5, 1'b0);
    push_exp(32'h118, 32'hA0000006, 4'h3, 1'b0);
    drain("starve");

    // Same destination: older B lands first, younger A value survives.
    qa.push_back(mk(32'h300, 32'h11111111, 4'h7));
    qb.push_back(mk(32'h400, 32'h22222222, 4'h7));
    push_exp(32'h400, 32'h22222222, 4'h7, 1'b0);
    push_exp(32'h300, 32'h11111111, 4'h7, 1'b0);
    drain("same_dst");
    check("r7_final_value", rf[7], 32'h11111111);

    // B alone writing R15 raises redirect.
    qb.push_back(mk(32'h2000, 32'hFFEEDDCC, 4'hF));
    push_exp(32'h2000, 32'hFFEEDDCC, 4'hF, 1'b1);
    drain("b_only_r15");

    // Idle cycle: strobe and redirect drop, payload holds.
    step();
    check("idle_wbe", bus.o_Sig_Write_Back_Enable, 1'b0);
    check("idle_redir", bus.o_Pc_Redirect, 1'b0);
    check("idle_pc_hold", bus.o_Pc, 32'h2000);
    check("idle_val_hold", bus.o_Write_Back_Value, 32'hFFEEDDCC);
    check("idle_dst_hold", bus.o_Destination, 4'hF);

    // Reset right after a registered grant; the pending request survives.
    qa.push_back(mk(32'h3000, 32'h55555555, 4'h9));
    qa.push_back(mk(32'h3004, 32'h66666666, 4'h2));
    push_exp(32'h3000, 32'h55555555, 4'h9, 1'b0);
    push_exp(32'h3004, 32'h66666666, 4'h2, 1'b0);
    step();
    check("pre_reset_wbe", bus.o_Sig_Write_Back_Enable, 1'b1);
    reset = 1'b0;
    step();
    check("midreset_a_ready", last_a_rdy, 1'b0);
    check("midreset_wbe", bus.o_Sig_Write_Back_Enable, 1'b0);
    check("midreset_dst", bus.o_Destination, 4'h0);
    check("midreset_pc", bus.o_Pc, 32'h0);
    reset = 1'b1;
    step();
    check("post_reset_regrant_wbe", bus.o_Sig_Write_Back_Enable, 1'b1);
    check("post_reset_regrant_dst", bus.o_Destination, 4'h2);
    drain("mid_reset");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
